// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Purpose:
//   One shared free-running counter drives NUM_CH LED channels. Each channel
//   can be set at runtime to off, on, blink (square wave) or breathe
//   (triangle-ramped PWM). A global active-low gate forces every LED inactive
//   without disturbing the counter or the breathe ramps. Pin polarity
//   inversion is done outside this block.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   cfg_we     in   config write strobe (one-cycle pulse)
//   cfg_ch     in   target channel index
//   cfg_mode   in   mode to write (0 off, 1 on, 2 blink, 3 breathe)
//   cfg_shift  in   rate select to write (clamped to DIV_W-1)
//   gate_n     in   global enable, active-low; 0 forces all LEDs to 0
//   led        out  registered LED drive, active-high, one bit per channel
//   cfg_err    out  one-cycle pulse after a write to an out-of-range channel
//
// Config interface: cfg_we is a plain strobe with no ready/back-pressure.
// Every cycle with cfg_we=1 is one write, consumed at that clock edge. A write
// to a valid channel updates mode/shift at that edge (the LED follows one
// edge later); a write to cfg_ch >= NUM_CH changes nothing and raises
// cfg_err for the following cycle.
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int NUM_CH    = 5,
  parameter int DIV_W     = 27,
  parameter int PWM_W     = 8,
  parameter int DEF_MODE  = 2,
  parameter int DEF_SHIFT = 23,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [4:0]        cfg_shift,
  input  logic              gate_n,
  output logic [NUM_CH-1:0] led,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic [4:0]       SHIFT_MAX = 5'(DIV_W - 1);
  localparam logic [4:0]       DEF_SH    = 5'((DEF_SHIFT > DIV_W - 1) ? (DIV_W - 1) : DEF_SHIFT);
  localparam logic [1:0]       DEF_M     = 2'(DEF_MODE);
  localparam logic [PWM_W-1:0] DUTY_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Shared counter and config decode
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  r_cnt;
  logic [4:0]        w_cfg_shift;
  logic              w_cfg_bad;
  logic [NUM_CH-1:0] w_nxt;
  logic [NUM_CH-1:0] r_led;
  logic              r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_cfg_shift = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
  assign w_cfg_bad   = cfg_we && (32'(cfg_ch) >= 32'(NUM_CH));

  // ---------------------------------------------------------------------------
  // Per-channel state: mode, rate select, breathe duty and ramp direction
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mode_t            r_mode;
    logic [4:0]       r_shift;
    logic [PWM_W-1:0] r_duty;
    logic             r_dir_down;
    logic             w_hit;
    logic             w_step;
    logic [DIV_W-1:0] w_shifted;
    logic [DIV_W-1:0] w_win_mask;

    assign w_hit     = cfg_we && (cfg_ch == CH_W'(g));
    assign w_shifted = r_cnt >> r_shift;

    // Mask of cnt[shift:0]; the double shift keeps shift=DIV_W-1 well defined
    // (all ones) without needing a wider intermediate.
    assign w_win_mask = ~(({DIV_W{1'b1}} << r_shift) << 1);
    assign w_step     = (r_mode == MODE_BREATHE) &&
                        ((r_cnt & w_win_mask) == w_win_mask);

    always_comb begin
      w_nxt[g] = 1'b0;
      unique case (r_mode)
        MODE_OFF:     w_nxt[g] = 1'b0;
        MODE_ON:      w_nxt[g] = 1'b1;
        MODE_BLINK:   w_nxt[g] = w_shifted[0];
        MODE_BREATHE: w_nxt[g] = (r_cnt[PWM_W-1:0] < r_duty);
        default:      w_nxt[g] = 1'b0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mode     <= mode_t'(DEF_M);
        r_shift    <= DEF_SH;
        r_duty     <= '0;
        r_dir_down <= 1'b0;
      end else if (w_hit) begin
        // A write always wins over a coincident breathe step.
        r_mode  <= mode_t'(cfg_mode);
        r_shift <= w_cfg_shift;
        if (mode_t'(cfg_mode) == MODE_BREATHE) begin
          r_duty     <= '0;
          r_dir_down <= 1'b0;
        end
      end else if (w_step) begin
        // Direction flips in the same step that reaches an end point, so the
        // ramp never wraps. The end-point guards only matter if the ramp
        // state were ever inconsistent.
        if (!r_dir_down) begin
          if (r_duty != DUTY_MAX) begin
            r_duty <= r_duty + 1'b1;
          end
          if (r_duty >= DUTY_MAX - 1'b1) begin
            r_dir_down <= 1'b1;
          end
        end else begin
          if (r_duty != '0) begin
            r_duty <= r_duty - 1'b1;
          end
          if (r_duty <= {{(PWM_W-1){1'b0}}, 1'b1}) begin
            r_dir_down <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers; the gate only masks the drive, never the ramps.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
      r_err <= 1'b0;
    end else begin
      r_led <= gate_n ? w_nxt : '0;
      r_err <= w_cfg_bad;
    end
  end

  assign led     = r_led;
  assign cfg_err = r_err;

endmodule
